// File: rtl/intxn_pkg.sv
// Shared intersection definitions: light encodings, lights bus field slices
// and the vehicle-sensor FSM state encoding.
package intxn_pkg;

  localparam int unsigned LIGHT_W = 3;

  localparam logic [LIGHT_W-1:0] LIGHT_RED = 3'b100;
  localparam logic [LIGHT_W-1:0] LIGHT_YEL = 3'b010;
  localparam logic [LIGHT_W-1:0] LIGHT_GRN = 3'b001;

  localparam int unsigned NS_HI = 5;
  localparam int unsigned NS_LO = 3;
  localparam int unsigned EW_HI = 2;
  localparam int unsigned EW_LO = 0;

  localparam int unsigned LIGHTS_W = 6;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQUEST  = 2'd1,
    SERVING  = 2'd2,
    COOLDOWN = 2'd3
  } sensor_state_e;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser on the raw road sensor followed by a stable-level
// debounce counter; sensor_db only follows after DEBOUNCE_CYCLES agreeing samples.
module sensor_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic sensor_raw,
  output logic sensor_db
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((DEBOUNCE_CYCLES > 0) ? (DEBOUNCE_CYCLES - 1) : 0);

  logic             sync_meta;
  logic             sensor_sync;
  logic [CNT_W-1:0] cnt;

  // Synchroniser chain
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_meta   <= 1'b0;
      sensor_sync <= 1'b0;
    end else begin
      sync_meta   <= sensor_raw;
      sensor_sync <= sync_meta;
    end
  end

  // Count consecutive disagreeing samples; the increment that would reach
  // DEBOUNCE_CYCLES instead adopts the new level and clears the count.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt       <= '0;
      sensor_db <= 1'b0;
    end else if (sensor_sync == sensor_db) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt       <= '0;
      sensor_db <= sensor_sync;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/car_sensor.sv
// Vehicle-detector front end: debounced E/W sensor latched into a request that
// is withdrawn once E/W is served, followed by an anti-starvation cooldown.
// Optional arrival counter enabled by defining CAR_SENSOR_COUNT_EN.
module car_sensor
  import intxn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned COOLDOWN_CYCLES = 50000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                sensor_raw,
  input  logic [LIGHTS_W-1:0] lights_in,
  output logic                car_detected,
  output logic                lights_fault,
  output logic [15:0]         car_count
);

  localparam int unsigned COUNT_W = 16;
  localparam int unsigned CD_W = (COOLDOWN_CYCLES > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;
  localparam logic [CD_W-1:0] CD_LOAD =
    CD_W'((COOLDOWN_CYCLES > 0) ? (COOLDOWN_CYCLES - 1) : 0);

  logic                sensor_db;
  logic [LIGHT_W-1:0]  ns_lights;
  logic [LIGHT_W-1:0]  ew_lights;
  logic                ew_green;
  logic                ew_red;
  logic                ns_green;
  logic                both_live;

  sensor_state_e       state;
  sensor_state_e       state_next;
  logic [CD_W-1:0]     cool_cnt;
  logic [CD_W-1:0]     cool_next;

  sensor_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock      (clock),
    .reset      (reset),
    .sensor_raw (sensor_raw),
    .sensor_db  (sensor_db)
  );

  // Exact-match decodes: non-one-hot patterns simply fail every decode.
  assign ns_lights = lights_in[NS_HI:NS_LO];
  assign ew_lights = lights_in[EW_HI:EW_LO];
  assign ew_green  = (ew_lights == LIGHT_GRN);
  assign ew_red    = (ew_lights == LIGHT_RED);
  assign ns_green  = (ns_lights == LIGHT_GRN);
  assign both_live = (ns_lights != LIGHT_RED) && (ew_lights != LIGHT_RED);

  // Next-state and cooldown counter; a fault (current or arriving) parks in IDLE.
  always_comb begin
    state_next = state;
    cool_next  = cool_cnt;
    if (lights_fault || both_live) begin
      state_next = IDLE;
      cool_next  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (sensor_db) state_next = REQUEST;
        end
        REQUEST: begin
          if (ew_green) state_next = SERVING;
        end
        SERVING: begin
          if (ew_red && ns_green) begin
            if (COOLDOWN_CYCLES == 0) begin
              state_next = IDLE;
            end else begin
              state_next = COOLDOWN;
              cool_next  = CD_LOAD;
            end
          end
        end
        COOLDOWN: begin
          if (cool_cnt == '0) state_next = IDLE;
          else                cool_next  = cool_cnt - CD_W'(1);
        end
        default: begin
          state_next = IDLE;
          cool_next  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cool_cnt     <= '0;
      car_detected <= 1'b0;
      lights_fault <= 1'b0;
    end else begin
      state        <= state_next;
      cool_cnt     <= cool_next;
      car_detected <= (state_next == REQUEST);
      lights_fault <= lights_fault | both_live;
    end
  end

`ifdef CAR_SENSOR_COUNT_EN
  logic db_prev;

  // Saturating count of debounced arrivals, independent of the fault flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      db_prev   <= 1'b0;
      car_count <= '0;
    end else begin
      db_prev <= sensor_db;
      if (sensor_db && !db_prev && (car_count != {COUNT_W{1'b1}}))
        car_count <= car_count + COUNT_W'(1);
    end
  end
`else
  assign car_count = 16'h0000;
`endif

endmodule

// File: tb/tb_car_sensor.sv
// Bench for car_sensor: directed scenarios plus randomized sensor/lights
// traffic checked every cycle against a behavioural model.
module tb_car_sensor;

  localparam int unsigned DEB  = 4;
  localparam int unsigned COOL = 8;
  localparam logic [5:0] IDLE_LIGHTS = 6'b001100;

`ifdef CAR_SENSOR_COUNT_EN
  localparam int EXP_PRESSES = 3;
`else
  localparam int EXP_PRESSES = 0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sensor_raw = 1'b0;
  logic [5:0]  lights_in = IDLE_LIGHTS;
  logic        car_detected;
  logic        lights_fault;
  logic [15:0] car_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  car_sensor #(
    .DEBOUNCE_CYCLES (DEB),
    .COOLDOWN_CYCLES (COOL)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .sensor_raw   (sensor_raw),
    .lights_in    (lights_in),
    .car_detected (car_detected),
    .lights_fault (lights_fault),
    .car_count    (car_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: raw history queue, window of synchronised samples,
  // and request/serve/cooldown flags driven by the light decodes.
  bit        raw_q[$];
  bit        win[$];
  bit        m_db, m_db_last, m_fault, m_req, m_serv;
  int        m_cool, m_count;
  bit        sync_now, old_db, live, flip;
  bit [2:0]  ns, ew;

  always @(posedge clock) begin
    if (reset) begin
      raw_q = '{1'b0, 1'b0};
      win.delete();
      for (int i = 0; i < DEB; i++) win.push_back(1'b0);
      m_db = 0; m_db_last = 0; m_fault = 0; m_req = 0; m_serv = 0;
      m_cool = 0; m_count = 0;
    end else begin
      ns   = lights_in[5:3];
      ew   = lights_in[2:0];
      live = (ns != 3'b100) && (ew != 3'b100);
      old_db = m_db;

      sync_now = raw_q[1];
      raw_q.push_front(sensor_raw);
      void'(raw_q.pop_back());
      win.push_front(sync_now);
      void'(win.pop_back());
      flip = 1'b1;
      foreach (win[i]) if (win[i] == old_db) flip = 1'b0;
      if (flip) m_db = !old_db;

      if (old_db && !m_db_last && m_count < 65535) m_count++;
      m_db_last = old_db;

      m_fault = m_fault | live;
      if (m_fault) begin
        m_req = 0; m_serv = 0; m_cool = 0;
      end else if (m_cool > 0) begin
        m_cool--;
      end else if (m_serv) begin
        if (ew == 3'b100 && ns == 3'b001) begin
          m_serv = 0;
          m_cool = COOL;
        end
      end else if (m_req) begin
        if (ew == 3'b001) begin
          m_req  = 0;
          m_serv = 1;
        end
      end else if (old_db) begin
        m_req = 1;
      end
    end
  end

  always @(negedge clock) begin
    if (started) begin
      check("model car_detected", 16'(car_detected), 16'(m_req));
      check("model lights_fault", 16'(lights_fault), 16'(m_fault));
`ifdef CAR_SENSOR_COUNT_EN
      check("model car_count", car_count, 16'(m_count));
`else
      check("model car_count", car_count, 16'h0000);
`endif
    end
  end

  task automatic ticks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int r;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    started = 1'b1;
    @(negedge clock);
    check("reset car_detected", 16'(car_detected), 16'h0);
    check("reset lights_fault", 16'(lights_fault), 16'h0);
    check("reset car_count", car_count, 16'h0);
    reset = 1'b0;

    // Short glitch never reaches the debounced level
    sensor_raw = 1'b1;
    ticks(3);
    sensor_raw = 1'b0;
    ticks(10);
    check("glitch car_detected", 16'(car_detected), 16'h0);
    check("glitch car_count", car_count, 16'h0);

    // Clean press: request on the 7th edge, latched after release
    sensor_raw = 1'b1;
    ticks(6);
    check("press edge6", 16'(car_detected), 16'h0);
    ticks(1);
    check("press edge7", 16'(car_detected), 16'h1);
    sensor_raw = 1'b0;
    ticks(10);
    check("press latched", 16'(car_detected), 16'h1);

    // Serve, then cooldown with a queued car
    lights_in  = 6'b100001;
    sensor_raw = 1'b1;
    ticks(1);
    check("served drop", 16'(car_detected), 16'h0);
    lights_in = IDLE_LIGHTS;
    ticks(9);
    check("cooldown hold", 16'(car_detected), 16'h0);
    ticks(1);
    check("queued request", 16'(car_detected), 16'h1);

    // Both green during REQUEST
    lights_in = 6'b001001;
    ticks(1);
    check("fault set", 16'(lights_fault), 16'h1);
    check("fault drop req", 16'(car_detected), 16'h0);
    lights_in = IDLE_LIGHTS;
    for (int i = 0; i < 3; i++) begin
      sensor_raw = 1'b0;
      ticks(8);
      sensor_raw = 1'b1;
      ticks(8);
    end
    check("fault sticky", 16'(lights_fault), 16'h1);
    check("fault no req", 16'(car_detected), 16'h0);

    // Reset clears fault, then reset mid-REQUEST
    pulse_reset();
    check("rst1 fault", 16'(lights_fault), 16'h0);
    ticks(7);
    check("rerequest", 16'(car_detected), 16'h1);
    pulse_reset();
    check("rst2 car_detected", 16'(car_detected), 16'h0);
    check("rst2 lights_fault", 16'(lights_fault), 16'h0);
    check("rst2 car_count", car_count, 16'h0);
    ticks(6);
    check("post rst edge6", 16'(car_detected), 16'h0);
    ticks(1);
    check("post rst edge7", 16'(car_detected), 16'h1);

    // Three presses
    pulse_reset();
    sensor_raw = 1'b0;
    ticks(10);
    for (int i = 0; i < 3; i++) begin
      sensor_raw = 1'b1;
      ticks(10);
      sensor_raw = 1'b0;
      ticks(10);
    end
    check("press count", car_count, 16'(EXP_PRESSES));

    // Randomized traffic
    for (int s = 0; s < 600; s++) begin
      r = $urandom_range(0, 99);
      if (r < 3) pulse_reset();
      sensor_raw = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 99);
      if      (r < 35) lights_in = 6'b001100;
      else if (r < 60) lights_in = 6'b100001;
      else if (r < 70) lights_in = 6'b100010;
      else if (r < 78) lights_in = 6'b010100;
      else if (r < 88) lights_in = 6'b100100;
      else if (r < 95) lights_in = 6'b000100;
      else if (r < 98) lights_in = 6'b100000;
      else             lights_in = 6'b001001;
      ticks($urandom_range(1, 12));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
